// File: rtl/mux_n_pipe.sv
// N-input pipelined mux with a 2-entry (main + skid) output buffer; external select or round-robin.
// Define MUX_SEL_CHECK_EN to add the registered sel_err output for out-of-range selects.
module mux_n_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 32,
  parameter int SEL_W      = 5,
  parameter int ARB_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic [SEL_W-1:0]            select,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
`ifdef MUX_SEL_CHECK_EN
  output logic                        sel_err,
`endif
  input  logic                        out_ready
);

  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_INPUTS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

  logic             mainValid_q, mainValid_d;
  logic [WIDTH-1:0] mainData_q, mainData_d;
  logic [SEL_W-1:0] mainSel_q, mainSel_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic [SEL_W-1:0] skidSel_q, skidSel_d;
  logic             canAccept_q, canAccept_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             selInRange;
  logic [SEL_W-1:0] grant;
  logic             grantOk;
  logic [SEL_W-1:0] hiIdx, loIdx;
  logic             hiFound, loFound;
  logic             accept;
  logic [WIDTH-1:0] acceptData;
  logic             pop;

  assign selInRange = ({1'b0, select} < NUM_IN_W);

  // Round-robin: prefer the lowest valid channel at or above ptr, else wrap to the lowest valid one.
  always_comb begin
    grant   = '0;
    grantOk = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    hiFound = 1'b0;
    loFound = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          loIdx   = i[SEL_W-1:0];
          loFound = 1'b1;
          if (i[SEL_W-1:0] >= ptr_q) begin
            hiIdx   = i[SEL_W-1:0];
            hiFound = 1'b1;
          end
        end
      end
      grant   = hiFound ? hiIdx : loIdx;
      grantOk = loFound;
    end else begin
      grant   = select;
      grantOk = selInRange;
    end
  end

  always_comb begin
    in_ready   = '0;
    acceptData = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i[SEL_W-1:0] == grant) begin
        in_ready[i] = canAccept_q && grantOk;
        acceptData  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |(in_valid & in_ready);
  assign pop    = !mainValid_q || out_ready;

  // Skid only fills when main is stalled; main refills from skid first so order is preserved.
  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    mainSel_d   = mainSel_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidSel_d   = skidSel_q;
    ptr_d       = ptr_q;
    if (pop) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainData_d  = skidData_q;
        mainSel_d   = skidSel_q;
        skidValid_d = 1'b0;
      end else begin
        mainValid_d = accept;
        if (accept) begin
          mainData_d = acceptData;
          mainSel_d  = grant;
        end
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = acceptData;
      skidSel_d   = grant;
    end
    if ((ARB_MODE == 1) && accept) begin
      ptr_d = (grant == LAST_IDX) ? '0 : grant + 1'b1;
    end
    canAccept_d = !skidValid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      mainSel_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidSel_q   <= '0;
      canAccept_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      mainSel_q   <= mainSel_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidSel_q   <= skidSel_d;
      canAccept_q <= canAccept_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = mainValid_q;
  assign out_data  = mainData_q;
  assign out_sel   = mainSel_q;

`ifdef MUX_SEL_CHECK_EN
  logic selErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selErr_q <= 1'b0;
    end else begin
      selErr_q <= (ARB_MODE == 0) && !selInRange && (|in_valid);
    end
  end

  assign sel_err = selErr_q;
`endif

endmodule
